// File: rtl/seven_seg_capture.sv
// Receive side of a 2-digit multiplexed 7-segment PMOD: synchronizes segment/digit
// pins, decodes stable glyphs and commits the displayed byte once consecutive frames agree.
module seven_seg_capture #(
  parameter int unsigned MIN_STABLE = 4,
  parameter int unsigned AGREE      = 2,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] seg_n,
  input  logic       digit_sel,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       value_update,
  output logic       seg_err
);

  localparam int unsigned SW = $clog2(MIN_STABLE + 1);
  localparam int unsigned AW = $clog2(AGREE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(MIN_STABLE);
  localparam logic [AW-1:0] AGREE_MAX = AW'(AGREE);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

  typedef enum logic [1:0] {HUNT, TENS, ONES} state_t;

  logic [6:0]    seg_m, seg_s, seg_p;
  logic          dsel_m, dsel_s, dsel_p;
  logic [SW-1:0] stab_cnt, stab_n;
  logic          latched;
  state_t        state, state_n;
  logic          got_tens, got_tens_n, got_ones, got_ones_n;
  logic [3:0]    tens_nib, tens_n, ones_nib, ones_n;
  logic [7:0]    prev_cand, prev_n, cand;
  logic [AW-1:0] agree_cnt, agree_n;
  logic [TW-1:0] to_cnt, to_n;
  logic          fall, rise, dedge, blank, latch_ev, legal, frame, err, commit, expire;
  logic [3:0]    nib;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_m  <= '1;
      seg_s  <= '1;
      seg_p  <= '1;
      dsel_m <= 1'b1;
      dsel_s <= 1'b1;
      dsel_p <= 1'b1;
    end else begin
      seg_m  <= seg_n;
      seg_s  <= seg_m;
      seg_p  <= seg_s;
      dsel_m <= digit_sel;
      dsel_s <= dsel_m;
      dsel_p <= dsel_s;
    end
  end

  assign fall  = dsel_p & ~dsel_s;
  assign rise  = ~dsel_p & dsel_s;
  assign dedge = fall | rise;
  assign blank = (seg_s == 7'h7F);

  always_comb begin
    stab_n = stab_cnt;
    if (dedge || blank)
      stab_n = '0;
    else if (seg_s == seg_p && stab_cnt != '0)
      stab_n = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + SW'(1);
    else
      stab_n = SW'(1);
  end

  // A digit_sel edge suppresses the latch; 'latched' limits it to once per phase.
  assign latch_ev = !dedge && !latched && (stab_cnt != STAB_MAX) && (stab_n == STAB_MAX);

  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    case (~seg_s)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    got_tens_n = got_tens;
    got_ones_n = got_ones;
    tens_n     = tens_nib;
    ones_n     = ones_nib;
    frame      = 1'b0;
    err        = 1'b0;
    case (state)
      HUNT: begin
        if (fall) begin
          state_n    = TENS;
          got_tens_n = 1'b0;
        end
      end
      TENS: begin
        if (fall)
          state_n = HUNT;
        else if (rise) begin
          if (got_tens) begin
            state_n    = ONES;
            got_ones_n = 1'b0;
          end else
            state_n = HUNT;
        end else if (latch_ev) begin
          if (legal) begin
            tens_n     = nib;
            got_tens_n = 1'b1;
          end else
            err = 1'b1;
        end
      end
      ONES: begin
        if (rise)
          state_n = HUNT;
        else if (fall) begin
          state_n    = TENS;
          got_tens_n = 1'b0;
          frame      = got_ones;
        end else if (latch_ev) begin
          if (legal) begin
            ones_n     = nib;
            got_ones_n = 1'b1;
          end else
            err = 1'b1;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  assign cand = {tens_nib, ones_nib};

  always_comb begin
    agree_n = agree_cnt;
    prev_n  = prev_cand;
    to_n    = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TW'(1);
    if (frame) begin
      to_n = '0;
      if (cand == prev_cand)
        agree_n = (agree_cnt == AGREE_MAX) ? agree_cnt : agree_cnt + AW'(1);
      else begin
        agree_n = AW'(1);
        prev_n  = cand;
      end
    end
    commit = frame && (agree_n == AGREE_MAX);
    // Commit takes priority over a same-cycle timeout expiry.
    expire = !commit && (to_n == TO_MAX);
    if (expire)
      agree_n = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stab_cnt     <= '0;
      latched      <= 1'b0;
      state        <= HUNT;
      got_tens     <= 1'b0;
      got_ones     <= 1'b0;
      tens_nib     <= '0;
      ones_nib     <= '0;
      prev_cand    <= '0;
      agree_cnt    <= '0;
      to_cnt       <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      value_update <= 1'b0;
      seg_err      <= 1'b0;
    end else begin
      stab_cnt     <= stab_n;
      latched      <= dedge ? 1'b0 : (latched | latch_ev);
      state        <= state_n;
      got_tens     <= got_tens_n;
      got_ones     <= got_ones_n;
      tens_nib     <= tens_n;
      ones_nib     <= ones_n;
      prev_cand    <= prev_n;
      agree_cnt    <= agree_n;
      to_cnt       <= to_n;
      seg_err      <= err;
      value_update <= commit && (!value_valid || cand != value);
      if (commit) begin
        value       <= cand;
        value_valid <= 1'b1;
      end else if (expire)
        value_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: table of decoded frames plus hand-written
// sequences for glitches, short phases, timeout, phase skipping and mid-frame reset.
module tb_seven_seg_capture;

  localparam int unsigned TO = 300;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] seg_n;
  logic       digit_sel;
  logic [7:0] value;
  logic       value_valid, value_update, seg_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned upd_cnt = 0;
  int unsigned err_cnt = 0;
  logic        seen_3b = 1'b0;
  int unsigned u0, e0;

  seven_seg_capture #(.MIN_STABLE(4), .AGREE(2), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .seg_n(seg_n), .digit_sel(digit_sel),
    .value(value), .value_valid(value_valid), .value_update(value_update), .seg_err(seg_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (value_update) upd_cnt++;
    if (seg_err) err_cnt++;
    if (value == 8'h3B) seen_3b = 1'b1;
  end

  typedef struct {
    logic [6:0]  t;
    logic [6:0]  o;
    logic [7:0]  v;
    int unsigned upd;
    int unsigned err;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic phase(input logic d, input logic [6:0] pat, input int lit,
                       input int gl_at, input logic [6:0] gl_pat);
    digit_sel = d;
    for (int i = 0; i < lit; i++) begin
      seg_n = (i == gl_at) ? ~gl_pat : ~pat;
      tick();
    end
    seg_n = '1;
    repeat (4) tick();
  endtask

  task automatic frame(input logic [6:0] t, input logic [6:0] o, input int tlit, input int gl_at);
    phase(1'b0, t, tlit, gl_at, 7'h7F);
    phase(1'b1, o, 8, -1, 7'h00);
  endtask

  task automatic close_frame();
    digit_sel = 1'b0;
    seg_n     = '1;
    repeat (6) tick();
  endtask

  initial begin
    tbl[0]  = '{7'h4F, 7'h77, 8'h3A, 1, 0};
    tbl[1]  = '{7'h66, 7'h5B, 8'h42, 1, 0};
    tbl[2]  = '{7'h3F, 7'h06, 8'h01, 1, 0};
    tbl[3]  = '{7'h6D, 7'h7D, 8'h56, 1, 0};
    tbl[4]  = '{7'h07, 7'h7F, 8'h78, 1, 0};
    tbl[5]  = '{7'h6F, 7'h7C, 8'h9B, 1, 0};
    tbl[6]  = '{7'h39, 7'h5E, 8'hCD, 1, 0};
    tbl[7]  = '{7'h79, 7'h71, 8'hEF, 1, 0};
    tbl[8]  = '{7'h79, 7'h01, 8'hEF, 0, 3};
    tbl[9]  = '{7'h40, 7'h71, 8'hEF, 0, 3};
    tbl[10] = '{7'h79, 7'h71, 8'hEF, 0, 0};

    RST_N = 1'b0; seg_n = '1; digit_sel = 1'b1;
    repeat (3) tick();
    check("rst_value", value, 8'h00);
    check("rst_valid", value_valid, 1'b0);
    check("rst_update", value_update, 1'b0);
    check("rst_err", seg_err, 1'b0);
    RST_N = 1'b1;
    repeat (3) tick();

    for (int k = 0; k < 11; k++) begin
      u0 = upd_cnt; e0 = err_cnt;
      repeat (3) frame(tbl[k].t, tbl[k].o, 8, -1);
      close_frame();
      check($sformatf("tbl%0d_value", k), value, tbl[k].v);
      check($sformatf("tbl%0d_valid", k), value_valid, 1'b1);
      check($sformatf("tbl%0d_upd", k), upd_cnt - u0, tbl[k].upd);
      check($sformatf("tbl%0d_err", k), err_cnt - e0, tbl[k].err);
    end

    // one disagreeing frame must not commit
    repeat (3) frame(7'h4F, 7'h77, 8, -1);
    close_frame();
    check("steady_value", value, 8'h3A);
    u0 = upd_cnt; seen_3b = 1'b0;
    frame(7'h4F, 7'h7C, 8, -1);
    repeat (2) frame(7'h4F, 7'h77, 8, -1);
    close_frame();
    check("odd_frame_value", value, 8'h3A);
    check("odd_frame_upd", upd_cnt - u0, 0);
    check("odd_frame_never_3b", seen_3b, 1'b0);

    // tens lit too briefly: frames dropped
    u0 = upd_cnt;
    repeat (3) frame(7'h06, 7'h06, 3, -1);
    close_frame();
    check("short_tens_value", value, 8'h3A);
    check("short_tens_upd", upd_cnt - u0, 0);

    // one-cycle glitch mid tens phase: still latches after restabilising
    u0 = upd_cnt;
    repeat (3) frame(7'h6D, 7'h6D, 8, 3);
    close_frame();
    check("glitch_value", value, 8'h55);
    check("glitch_upd", upd_cnt - u0, 1);

    // timeout
    repeat (3) frame(7'h66, 7'h5B, 8, -1);
    close_frame();
    check("to_commit", value, 8'h42);
    repeat (TO - 20) tick();
    check("to_before_valid", value_valid, 1'b1);
    repeat (30) tick();
    check("to_after_valid", value_valid, 1'b0);
    check("to_after_value", value, 8'h42);
    u0 = upd_cnt;
    repeat (2) frame(7'h66, 7'h5B, 8, -1);
    close_frame();
    check("to_recommit_valid", value_valid, 1'b1);
    check("to_recommit_upd", upd_cnt - u0, 1);

    // skipped ones phase: no frame completes
    u0 = upd_cnt;
    repeat (3) begin
      phase(1'b0, 7'h06, 8, -1, 7'h00);
      digit_sel = 1'b1; tick();
    end
    close_frame();
    check("skip_value", value, 8'h42);
    check("skip_upd", upd_cnt - u0, 0);

    // reset mid tens phase
    digit_sel = 1'b0; seg_n = ~7'h4F;
    repeat (3) tick();
    #2 RST_N = 1'b0;
    #1;
    check("midrst_value", value, 8'h00);
    check("midrst_valid", value_valid, 1'b0);
    tick(); tick();
    RST_N = 1'b1;
    seg_n = '1;
    u0 = upd_cnt;
    frame(7'h66, 7'h5B, 8, -1);
    close_frame();
    check("midrst_one_frame_valid", value_valid, 1'b0);
    frame(7'h66, 7'h5B, 8, -1);
    close_frame();
    check("midrst_two_frame_valid", value_valid, 1'b1);
    check("midrst_two_frame_value", value, 8'h42);
    check("midrst_upd", upd_cnt - u0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
